axi_read: RTL



---
 rtl/axi_read.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/axi_read.sv
// axi_read: AXI4 INCR burst-read master; returned beats are forwarded as an AXI-Stream master.
// Optional define AXI_RD_RESP_CHECK_EN compiles the sticky rd_err response/burst-length check.
module axi_read #(
   parameter int RD_FLIP_BYTE  = 0,
   parameter int RD_ADDR_WIDTH = 32,
   parameter int RD_DATA_WIDTH = 64,
   parameter int RD_LIN        = 16,
   parameter int RD_ADDR_STEP  = 4096,
   parameter int RD_ADDR_TOP   = 32'h10000
) (
   input  logic                     M_RD_aclk,
   input  logic                     M_RD_areset,
   input  logic                     rd_req,
   output logic                     rd_busy,
   output logic                     rd_err,
   output logic [RD_DATA_WIDTH-1:0] M_RD_tdata,
   output logic                     M_RD_tvalid,
   output logic                     M_RD_tlast,
   input  logic                     M_RD_tready,
   output logic                     m_axi_arid,
   output logic [RD_ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]               m_axi_arlen,
   output logic [2:0]               m_axi_arsize,
   output logic [1:0]               m_axi_arburst,
   output logic                     m_axi_arlock,
   output logic [3:0]               m_axi_arcache,
   output logic [2:0]               m_axi_arprot,
   output logic [3:0]               m_axi_arqos,
   output logic                     m_axi_arvalid,
   input  logic                     m_axi_arready,
   input  logic                     m_axi_rid,
   input  logic [RD_DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]               m_axi_rresp,
   input  logic                     m_axi_rlast,
   input  logic                     m_axi_rvalid,
   output logic                     m_axi_rready
);

   localparam logic [31:0] ADDR_STEP = 32'(RD_ADDR_STEP);
   localparam logic [31:0] ADDR_WRAP = 32'(RD_ADDR_TOP - RD_ADDR_STEP);

   typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA, RD_STOP} rd_state_t;

   rd_state_t                state, state_nxt;
   logic [31:0]              addr_cnt;
   logic [8:0]               beat_cnt;
   logic                     ar_hs;
   logic                     r_hs;
   logic [RD_DATA_WIDTH-1:0] rdata_flip;
   logic                     unused_ok;

   assign ar_hs   = m_axi_arvalid & m_axi_arready;
   // rready follows tready only in RD_DATA, so the R handshake is qualified the same way
   assign r_hs    = (state == RD_DATA) & m_axi_rvalid & M_RD_tready;
   assign rd_busy = (state != RD_IDLE);

   assign m_axi_arid    = 1'b0;
   assign m_axi_arlen   = 8'(RD_LIN - 1);
   assign m_axi_arsize  = 3'($clog2(RD_DATA_WIDTH / 8));
   assign m_axi_arburst = 2'b01;
   assign m_axi_arlock  = 1'b0;
   assign m_axi_arcache = 4'd3;
   assign m_axi_arprot  = 3'd0;
   assign m_axi_arqos   = 4'd0;

   always_ff @(posedge M_RD_aclk) begin
      if (M_RD_areset) state <= RD_IDLE;
      else             state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RD_IDLE: if (rd_req)                state_nxt = RD_ADDR;
         RD_ADDR: if (ar_hs)                 state_nxt = RD_DATA;
         RD_DATA: if (r_hs && m_axi_rlast)   state_nxt = RD_STOP;
         RD_STOP:                            state_nxt = RD_IDLE;
         default:                            state_nxt = RD_IDLE;
      endcase
   end

   always_ff @(posedge M_RD_aclk) begin
      if (M_RD_areset) begin
         m_axi_arvalid <= 1'b0;
         m_axi_araddr  <= '0;
      end else if (state == RD_IDLE && rd_req) begin
         m_axi_arvalid <= 1'b1;
         m_axi_araddr  <= RD_ADDR_WIDTH'(addr_cnt);
      end else if (ar_hs) begin
         m_axi_arvalid <= 1'b0;
      end
   end

   always_ff @(posedge M_RD_aclk) begin
      if (M_RD_areset) begin
         addr_cnt <= '0;
         beat_cnt <= '0;
      end else begin
         if (state == RD_STOP)
            addr_cnt <= (addr_cnt >= ADDR_WRAP) ? '0 : addr_cnt + ADDR_STEP;
         if (r_hs && m_axi_rlast)
            beat_cnt <= '0;
         else if (r_hs)
            beat_cnt <= beat_cnt + 9'd1;
      end
   end

   always_comb begin
      rdata_flip = '0;
      for (int unsigned i = 0; i < RD_DATA_WIDTH / 8; i++)
         rdata_flip[8*i +: 8] = m_axi_rdata[RD_DATA_WIDTH - 8 - 8*i +: 8];
   end

   always_comb begin
      M_RD_tvalid  = 1'b0;
      M_RD_tlast   = 1'b0;
      M_RD_tdata   = '0;
      m_axi_rready = 1'b0;
      if (state == RD_DATA) begin
         M_RD_tvalid  = m_axi_rvalid;
         M_RD_tlast   = m_axi_rlast;
         M_RD_tdata   = (RD_FLIP_BYTE != 0) ? rdata_flip : m_axi_rdata;
         m_axi_rready = M_RD_tready;
      end
   end

`ifdef AXI_RD_RESP_CHECK_EN
   localparam logic [8:0] LAST_BEAT = 9'(RD_LIN - 1);

   always_ff @(posedge M_RD_aclk) begin
      if (M_RD_areset)
         rd_err <= 1'b0;
      else if (r_hs && ((m_axi_rresp != 2'b00) || (m_axi_rlast && beat_cnt != LAST_BEAT)))
         rd_err <= 1'b1;
   end

   assign unused_ok = m_axi_rid;
`else
   assign rd_err    = 1'b0;
   assign unused_ok = ^{m_axi_rid, m_axi_rresp, beat_cnt};
`endif

endmodule
